prbs_lock_checker: RTL and testbench

PRBS_LOCK_CHECKER -- requirements
Module: prbs_lock_checker

---
 rtl/ber_pkg.sv | 51 +++++
 rtl/ber_sat_counter.sv | 37 +++
 rtl/prbs_lock_checker.sv | 180 ++++++++++++++++++
 tb/tb_prbs_lock_checker.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// Shared definitions for the PRBS bit-error-rate checker: mode encoding,
// polynomial tap positions and the lock FSM state type.
package ber_pkg;

    localparam logic [1:0] MODE_PRBS7  = 2'b00;
    localparam logic [1:0] MODE_PRBS15 = 2'b01;
    localparam logic [1:0] MODE_PRBS23 = 2'b10;
    localparam logic [1:0] MODE_PRBS31 = 2'b11;

    // (N,T) tap pairs: predicted bit = h[N-1] ^ h[T-1]
    localparam int PRBS7_N  = 7;
    localparam int PRBS7_T  = 6;
    localparam int PRBS15_N = 15;
    localparam int PRBS15_T = 14;
    localparam int PRBS23_N = 23;
    localparam int PRBS23_T = 18;
    localparam int PRBS31_N = 31;
    localparam int PRBS31_T = 28;

    typedef logic [0:0] state_t;
    localparam state_t ST_HUNT   = 1'b0;
    localparam state_t ST_LOCKED = 1'b1;

    function automatic logic predict_bit(input logic [1:0] mode, input logic [30:0] h);
        case (mode)
            MODE_PRBS7:  predict_bit = h[PRBS7_N-1]  ^ h[PRBS7_T-1];
            MODE_PRBS15: predict_bit = h[PRBS15_N-1] ^ h[PRBS15_T-1];
            MODE_PRBS23: predict_bit = h[PRBS23_N-1] ^ h[PRBS23_T-1];
            default:     predict_bit = h[PRBS31_N-1] ^ h[PRBS31_T-1];
        endcase
    endfunction

    function automatic logic [5:0] tap_len(input logic [1:0] mode);
        case (mode)
            MODE_PRBS7:  tap_len = 6'd7;
            MODE_PRBS15: tap_len = 6'd15;
            MODE_PRBS23: tap_len = 6'd23;
            default:     tap_len = 6'd31;
        endcase
    endfunction

    function automatic logic [30:0] len_mask(input logic [1:0] mode);
        case (mode)
            MODE_PRBS7:  len_mask = 31'h0000_007F;
            MODE_PRBS15: len_mask = 31'h0000_7FFF;
            MODE_PRBS23: len_mask = 31'h007F_FFFF;
            default:     len_mask = 31'h7FFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ber_sat_counter.sv
// Saturating up-counter with sticky saturation flag and synchronous clear.
module ber_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_NEAR = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_sat;

    // Clear beats increment; the flag sets on the step that reaches all-ones.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
            r_sat   <= r_sat | (r_count == CNT_NEAR);
        end
    end

    assign count = r_count;
    assign sat   = r_sat;

endmodule

// File: rtl/prbs_lock_checker.sv
// PRBS7/15/23/31 receive checker: hunts for lock on the incoming stream,
// then counts checked and errored bits and drops lock on a bad window.
module prbs_lock_checker
    import ber_pkg::*;
#(
    parameter int TTB_W      = 32,
    parameter int TEB_W      = 16,
    parameter int SYNC_LEN   = 64,
    parameter int WIN_LEN    = 1024,
    parameter int LOS_THRESH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             prbs_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [TTB_W-1:0] ttb_out,
    output logic [TEB_W-1:0] teb_out,
    output logic             ttb_sat,
    output logic             teb_sat,
    output logic             los_event
);

    localparam int MATCH_W = $clog2(SYNC_LEN + 1);
    localparam int WIN_W   = $clog2(WIN_LEN + 1);
    localparam int WERR_W  = $clog2(LOS_THRESH + 1);

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(SYNC_LEN - 1);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = {{(MATCH_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0]   WIN_V      = WIN_W'(WIN_LEN);
    localparam logic [WIN_W-1:0]   WIN_ONE    = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [WERR_W-1:0]  LOS_V      = WERR_W'(LOS_THRESH);

    state_t             r_state;
    logic [30:0]        r_h;
    logic [5:0]         r_fill;
    logic [MATCH_W-1:0] r_match;
    logic [WIN_W-1:0]   r_wcnt;
    logic [WERR_W-1:0]  r_werr;
    logic [1:0]         r_mode_prev;
    logic               r_locked;
    logic               r_err_pulse;
    logic               r_los_event;

    state_t             w_state_n;
    logic [30:0]        w_h_n;
    logic [30:0]        w_h_shift;
    logic [5:0]         w_fill_n;
    logic [5:0]         w_n;
    logic [MATCH_W-1:0] w_match_n;
    logic [WIN_W-1:0]   w_wcnt_n;
    logic [WERR_W-1:0]  w_werr_n;
    logic               w_pred;
    logic               w_mism;
    logic               w_mode_chg;
    logic               w_err_n;
    logic               w_los_n;
    logic               w_ttb_inc;
    logic               w_teb_inc;

    // Next-state logic: mode change has priority, then idle, then LOCKED/HUNT.
    always_comb begin
        w_pred     = predict_bit(mode, r_h);
        w_mism     = w_pred ^ prbs_in;
        w_n        = tap_len(mode);
        w_mode_chg = (mode != r_mode_prev);
        // Once locked, the local prediction feeds the history so errors do not propagate.
        w_h_shift  = {r_h[29:0], (r_state == ST_LOCKED) ? w_pred : prbs_in};
        w_state_n  = r_state;
        w_h_n      = r_h;
        w_fill_n   = r_fill;
        w_match_n  = r_match;
        w_wcnt_n   = r_wcnt;
        w_werr_n   = r_werr;
        w_err_n    = 1'b0;
        w_los_n    = 1'b0;
        w_ttb_inc  = 1'b0;
        w_teb_inc  = 1'b0;
        if (w_mode_chg) begin
            w_state_n = ST_HUNT;
            w_fill_n  = 6'd0;
            w_match_n = '0;
            w_wcnt_n  = '0;
            w_werr_n  = '0;
            w_los_n   = (r_state == ST_LOCKED);
        end else if (!bit_valid) begin
            w_state_n = r_state;
        end else if (r_state == ST_LOCKED) begin
            w_h_n     = w_h_shift;
            w_ttb_inc = 1'b1;
            w_teb_inc = w_mism;
            w_err_n   = w_mism;
            w_wcnt_n  = r_wcnt + WIN_ONE;
            w_werr_n  = r_werr + WERR_W'(w_mism);
            if (w_werr_n >= LOS_V) begin
                w_state_n = ST_HUNT;
                w_los_n   = 1'b1;
                w_fill_n  = 6'd0;
                w_match_n = '0;
                w_wcnt_n  = '0;
                w_werr_n  = '0;
            end else if (w_wcnt_n == WIN_V) begin
                w_wcnt_n  = '0;
                w_werr_n  = '0;
            end else begin
                w_state_n = ST_LOCKED;
            end
        end else begin
            w_h_n = w_h_shift;
            if (r_fill < w_n) begin
                w_fill_n = r_fill + 6'd1;
            end else if (w_mism) begin
                w_match_n = '0;
            end else if (r_match != MATCH_LAST) begin
                w_match_n = r_match + MATCH_ONE;
            end else begin
                // An all-zero history satisfies every recurrence; never lock on it.
                w_match_n = '0;
                if ((w_h_shift & len_mask(mode)) != 31'd0) begin
                    w_state_n = ST_LOCKED;
                end else begin
                    w_state_n = ST_HUNT;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= ST_HUNT;
            r_h         <= 31'd0;
            r_fill      <= 6'd0;
            r_match     <= '0;
            r_wcnt      <= '0;
            r_werr      <= '0;
            r_mode_prev <= mode;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_los_event <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_h         <= w_h_n;
            r_fill      <= w_fill_n;
            r_match     <= w_match_n;
            r_wcnt      <= w_wcnt_n;
            r_werr      <= w_werr_n;
            r_mode_prev <= mode;
            r_locked    <= (w_state_n == ST_LOCKED);
            r_err_pulse <= w_err_n;
            r_los_event <= w_los_n;
        end
    end

    ber_sat_counter #(.WIDTH(TTB_W)) u_ttb (
        .clock (clock),
        .reset (reset),
        .inc   (w_ttb_inc),
        .clear (clear),
        .count (ttb_out),
        .sat   (ttb_sat)
    );

    ber_sat_counter #(.WIDTH(TEB_W)) u_teb (
        .clock (clock),
        .reset (reset),
        .inc   (w_teb_inc),
        .clear (clear),
        .count (teb_out),
        .sat   (teb_sat)
    );

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign los_event = r_los_event;

endmodule

// File: tb/tb_prbs_lock_checker.sv
// Bench for prbs_lock_checker: scenario table, directed corner sequences and
// a randomized phase, all compared cycle by cycle against a behavioural model.
`timescale 1ns/1ps
module tb_prbs_lock_checker;

    localparam int SYNC = 64;
    localparam int WIN  = 1024;
    localparam int LOS  = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        bit_valid = 1'b0;
    logic        prbs_in = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  mode = 2'b00;

    logic        a_locked, a_err, a_los, a_ttbs, a_tebs;
    logic [31:0] a_ttb;
    logic [15:0] a_teb;
    logic        b_locked, b_err, b_los, b_ttbs, b_tebs;
    logic [7:0]  b_ttb;
    logic [15:0] b_teb;

    always #5 clock = ~clock;

    prbs_lock_checker dut_a (
        .clock(clock), .reset(reset), .mode(mode), .prbs_in(prbs_in),
        .bit_valid(bit_valid), .clear(clear), .locked(a_locked), .err_pulse(a_err),
        .ttb_out(a_ttb), .teb_out(a_teb), .ttb_sat(a_ttbs), .teb_sat(a_tebs),
        .los_event(a_los));

    prbs_lock_checker #(.TTB_W(8)) dut_b (
        .clock(clock), .reset(reset), .mode(mode), .prbs_in(prbs_in),
        .bit_valid(bit_valid), .clear(clear), .locked(b_locked), .err_pulse(b_err),
        .ttb_out(b_ttb), .teb_out(b_teb), .ttb_sat(b_ttbs), .teb_sat(b_tebs),
        .los_event(b_los));

    int errors = 0;
    int checks = 0;
    int n_err = 0;
    int n_los = 0;
    int n_lock = 0;

    // Reference model state
    bit     m_h[$];
    bit     m_lock, m_err, m_los, m_ttbs, m_tebs, m_ttbs8;
    int     m_fill, m_match, m_wcnt, m_werr;
    longint m_ttb, m_teb, m_ttb8;
    logic [1:0] m_prev;

    // Stimulus generator history (index 0 newest)
    bit g_h[$];

    function automatic int tap_n(input logic [1:0] md);
        case (md)
            2'b00:   return 7;
            2'b01:   return 15;
            2'b10:   return 23;
            default: return 31;
        endcase
    endfunction

    function automatic int tap_t(input logic [1:0] md);
        case (md)
            2'b00:   return 6;
            2'b01:   return 14;
            2'b10:   return 18;
            default: return 28;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic [1:0] md, input logic v,
                              input logic b, input logic clr);
        int n, t;
        bit pred, mism, ttb_inc, teb_inc, nz;
        m_err = 1'b0;
        m_los = 1'b0;
        if (!rst) begin
            m_h = {};
            repeat (31) m_h.push_front(1'b0);
            m_lock = 1'b0; m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
            m_ttb = 0; m_teb = 0; m_ttb8 = 0;
            m_ttbs = 1'b0; m_tebs = 1'b0; m_ttbs8 = 1'b0;
            m_prev = md;
            return;
        end
        n = tap_n(md);
        t = tap_t(md);
        ttb_inc = 1'b0;
        teb_inc = 1'b0;
        if (md != m_prev) begin
            m_los = m_lock;
            m_lock = 1'b0; m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
        end else if (v) begin
            pred = m_h[n-1] ^ m_h[t-1];
            mism = (pred != bit'(b));
            if (m_lock) begin
                m_h.push_front(pred);
                void'(m_h.pop_back());
                ttb_inc = 1'b1;
                teb_inc = mism;
                m_err = mism;
                m_wcnt++;
                m_werr += int'(mism);
                if (m_werr >= LOS) begin
                    m_lock = 1'b0; m_los = 1'b1;
                    m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
                end else if (m_wcnt == WIN) begin
                    m_wcnt = 0; m_werr = 0;
                end
            end else begin
                m_h.push_front(bit'(b));
                void'(m_h.pop_back());
                if (m_fill < n) m_fill++;
                else if (mism) m_match = 0;
                else begin
                    m_match++;
                    if (m_match == SYNC) begin
                        m_match = 0;
                        nz = 1'b0;
                        for (int i = 0; i < n; i++) if (m_h[i]) nz = 1'b1;
                        if (nz) m_lock = 1'b1;
                    end
                end
            end
        end
        m_prev = md;
        if (clr) begin
            m_ttb = 0; m_teb = 0; m_ttb8 = 0;
            m_ttbs = 1'b0; m_tebs = 1'b0; m_ttbs8 = 1'b0;
        end else begin
            if (ttb_inc) begin
                if (m_ttb < 64'hFFFF_FFFF) m_ttb++;
                if (m_ttb == 64'hFFFF_FFFF) m_ttbs = 1'b1;
                if (m_ttb8 < 255) m_ttb8++;
                if (m_ttb8 == 255) m_ttbs8 = 1'b1;
            end
            if (teb_inc) begin
                if (m_teb < 65535) m_teb++;
                if (m_teb == 65535) m_tebs = 1'b1;
            end
        end
    endtask

    task automatic step(input logic v, input logic b, input logic clr);
        bit_valid = v;
        prbs_in   = b;
        clear     = clr;
        @(posedge clock);
        model_step(reset, mode, v, b, clr);
        #1;
        check("a_flags", 64'({a_locked, a_err, a_los, a_ttbs, a_tebs}),
              64'({m_lock, m_err, m_los, m_ttbs, m_tebs}));
        check("a_ttb", 64'(a_ttb), m_ttb);
        check("a_teb", 64'(a_teb), m_teb);
        check("b_flags", 64'({b_locked, b_err, b_los, b_ttbs, b_tebs}),
              64'({m_lock, m_err, m_los, m_ttbs8, m_tebs}));
        check("b_ttb", 64'(b_ttb), m_ttb8);
        check("b_teb", 64'(b_teb), m_teb);
        if (a_err) n_err++;
        if (a_los) n_los++;
        if (a_locked) n_lock++;
    endtask

    task automatic gen_seed();
        g_h = {};
        for (int i = 0; i < 31; i++) g_h.push_back(bit'($urandom_range(0, 1)));
        g_h[0] = 1'b1;
    endtask

    task automatic send(input bit inv);
        bit b;
        b = g_h[tap_n(mode)-1] ^ g_h[tap_t(mode)-1];
        g_h.push_front(b);
        void'(g_h.pop_back());
        step(1'b1, b ^ inv, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    // Clean bits until the DUT reports lock; bounded, latency checked.
    task automatic acquire(input string name);
        int nb;
        nb = 0;
        while (!a_locked && nb < 200) begin
            send(1'b0);
            nb++;
        end
        check({name, "_lock_in_time"}, 64'(nb <= tap_n(mode) + SYNC + 2 && a_locked), 64'd1);
    endtask

    typedef struct {
        logic [1:0] md;
        int         nbits;
        int         period;
        int         exp_ttb;
        int         exp_teb;
        bit         exp_lock;
    } scen_t;

    scen_t tbl[5];

    initial begin
        int  burst, r;
        bit  inv, clr;

        tbl[0] = '{2'b00, 10000,   0, 10000,  0, 1'b1};
        tbl[1] = '{2'b01,  5000, 100,  5000, 50, 1'b1};
        tbl[2] = '{2'b10,  2000,   0,  2000,  0, 1'b1};
        tbl[3] = '{2'b11,  3000,  50,  3000, 60, 1'b1};
        tbl[4] = '{2'b01,  2000,  10,   640, 64, 1'b0};

        do_reset();
        check("reset_ttb", 64'(a_ttb), 64'd0);
        check("reset_locked", 64'(a_locked), 64'd0);

        for (int s = 0; s < 5; s++) begin
            mode = tbl[s].md;
            do_reset();
            gen_seed();
            acquire($sformatf("scen%0d", s));
            n_err = 0;
            for (int i = 0; i < tbl[s].nbits; i++)
                send(tbl[s].period != 0 && (i % tbl[s].period) == tbl[s].period - 1);
            check($sformatf("scen%0d_ttb", s), 64'(a_ttb), 64'(tbl[s].exp_ttb));
            check($sformatf("scen%0d_teb", s), 64'(a_teb), 64'(tbl[s].exp_teb));
            check($sformatf("scen%0d_pulses", s), 64'(n_err), 64'(tbl[s].exp_teb));
            check($sformatf("scen%0d_locked", s), 64'(a_locked), 64'(tbl[s].exp_lock));
        end

        // Burst of inverted bits in PRBS31 forces loss of sync, then relock
        mode = 2'b11;
        do_reset();
        gen_seed();
        acquire("los_first");
        repeat (100) send(1'b0);
        n_los = 0;
        repeat (64) send(1'b1);
        check("los_count", 64'(n_los), 64'd1);
        check("los_unlocked", 64'(a_locked), 64'd0);
        acquire("los_relock");
        check("los_relock_count", 64'(n_los), 64'd1);

        // Constant zero never locks in any mode
        for (int md = 0; md < 4; md++) begin
            mode = 2'(md);
            do_reset();
            n_lock = 0;
            repeat (1000) step(1'b1, 1'b0, 1'b0);
            check($sformatf("zero_mode%0d_locks", md), 64'(n_lock), 64'd0);
        end

        // 8-bit total counter saturates, clear with a valid bit wins
        mode = 2'b00;
        do_reset();
        gen_seed();
        acquire("sat");
        repeat (300) send(1'b0);
        check("sat_ttb8", 64'(b_ttb), 64'd255);
        check("sat_flag8", 64'(b_ttbs), 64'd1);
        check("sat_ttb32", 64'(a_ttb), 64'd300);
        g_h.push_front(g_h[6] ^ g_h[5]);
        void'(g_h.pop_back());
        step(1'b1, g_h[0], 1'b1);
        check("clr_ttb8", 64'(b_ttb), 64'd0);
        check("clr_flag8", 64'(b_ttbs), 64'd0);
        check("clr_ttb32", 64'(a_ttb), 64'd0);
        check("clr_keeps_lock", 64'(a_locked), 64'd1);

        // Mode switch mid-stream drops lock, counters retained through relock
        mode = 2'b10;
        do_reset();
        gen_seed();
        acquire("mchg_first");
        repeat (500) send(1'b0);
        mode = 2'b00;
        gen_seed();
        send(1'b0);
        check("mchg_unlocked", 64'(a_locked), 64'd0);
        check("mchg_los", 64'(a_los), 64'd1);
        acquire("mchg_relock");
        check("mchg_ttb_kept", 64'(a_ttb), 64'd500);
        repeat (100) send(1'b0);
        check("mchg_ttb_more", 64'(a_ttb), 64'd600);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        check("midlock_reset_locked", 64'(a_locked), 64'd0);
        check("midlock_reset_ttb", 64'(a_ttb), 64'd0);

        // Randomized traffic: idle gaps, errors, bursts, clears, mode changes, resets
        mode = 2'($urandom_range(0, 3));
        do_reset();
        gen_seed();
        burst = 0;
        for (int c = 0; c < 15000; c++) begin
            r = int'($urandom_range(0, 9999));
            if (r < 3) begin
                reset = 1'b0;
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                reset = 1'b1;
                continue;
            end
            if (r < 8) begin
                mode = 2'($urandom_range(0, 3));
                gen_seed();
            end
            clr = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 1'($urandom_range(0, 1)), clr);
            end else begin
                if (burst == 0 && $urandom_range(0, 1499) == 0) burst = 70;
                inv = (burst > 0) || ($urandom_range(0, 299) == 0);
                if (burst > 0) burst--;
                g_h.push_front(g_h[tap_n(mode)-1] ^ g_h[tap_t(mode)-1]);
                void'(g_h.pop_back());
                step(1'b1, g_h[0] ^ inv, clr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
